unidade_load_store: RTL



---
 rtl/lsu_pkg.sv | 20 ++
 rtl/alinhador_bytes.sv | 64 ++++++
 rtl/unidade_load_store.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store unit.
//   - size encodings for byte/half/word accesses
//   - FSM state type
//   - lane_lsb(): bit position of a byte lane for a given endianness
package lsu_pkg;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   typedef enum logic [1:0] {IDLE, RD, WR, FIN} lsu_state_e;

   // Little endian: lane k at bits [8k+7:8k]; big endian: lane k at [31-8k:24-8k].
   function automatic logic [4:0] lane_lsb(input logic [1:0] lane, input bit big_endian);
      logic [4:0] le_pos;
      le_pos = {lane, 3'b000};
      return big_endian ? 5'(5'd24 - le_pos) : le_pos;
   endfunction

endpackage

// File: rtl/alinhador_bytes.sv
// alinhador_bytes: combinational byte-lane aligner for the load/store unit.
//   Loads : extracts the addressed byte/half from rword and sign/zero-extends it.
//   Stores: replaces the addressed lane(s) of rword with wdata[7:0] / wdata[15:0].
// Ports:
//   size       in  2   access size (SZ_BYTE/SZ_HALF/SZ_WORD)
//   offset     in  2   byte offset within the word (already aligned for halves/words)
//   sign_ext   in  1   1 = sign-extend loads, 0 = zero-extend
//   rword      in  32  word read from memory
//   wdata      in  32  right-justified store data
//   load_data  out 32  extended load result
//   store_word out 32  merged word to write back
module alinhador_bytes
   import lsu_pkg::*;
#(
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic [1:0]  size,
   input  logic [1:0]  offset,
   input  logic        sign_ext,
   input  logic [31:0] rword,
   input  logic [31:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] store_word
);

   logic [4:0]  pos_b;
   logic [4:0]  pos_lo;   // lane 2h of the addressed half
   logic [4:0]  pos_hi;   // lane 2h+1 of the addressed half
   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      pos_b  = lane_lsb(offset, BIG_ENDIAN);
      pos_lo = lane_lsb({offset[1], 1'b0}, BIG_ENDIAN);
      pos_hi = lane_lsb({offset[1], 1'b1}, BIG_ENDIAN);
      byte_v = rword[pos_b +: 8];
      // The lower-addressed lane is the most significant byte in big endian.
      if (BIG_ENDIAN) half_v = {rword[pos_lo +: 8], rword[pos_hi +: 8]};
      else            half_v = {rword[pos_hi +: 8], rword[pos_lo +: 8]};

      load_data  = rword;
      store_word = wdata;
      case (size)
         SZ_BYTE: begin
            load_data  = {{24{sign_ext & byte_v[7]}}, byte_v};
            store_word = rword;
            store_word[pos_b +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_data  = {{16{sign_ext & half_v[15]}}, half_v};
            store_word = rword;
            if (BIG_ENDIAN) begin
               store_word[pos_lo +: 8] = wdata[15:8];
               store_word[pos_hi +: 8] = wdata[7:0];
            end else begin
               store_word[pos_lo +: 8] = wdata[7:0];
               store_word[pos_hi +: 8] = wdata[15:8];
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/unidade_load_store.sv
// unidade_load_store: load/store unit between the CPU memory stage and a word-addressed
// data memory that writes on posedge and reads on negedge (read data one cycle after
// the address is registered). Sub-word stores use read-modify-write.
// Build option: define LSU_ALIGN_CHECK_EN to report misaligned half/word accesses as
// errors; when undefined the low address bits are forced aligned instead.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   req, wr, size      request strobe (sampled in IDLE), 1=store, access size
//   sign_ext           loads: 1 sign-extend, 0 zero-extend
//   addr, wdata        byte address, right-justified store data
//   busy, done, err    stall, completion pulse, error (valid with done)
//   rdata              last load result
//   mem_we, mem_addr   memory write enable, word index
//   mem_wdata          memory write data
//   mem_rdata          memory read data
module unidade_load_store
   import lsu_pkg::*;
#(
   parameter int unsigned MEM_WORDS  = 150,
   parameter bit          BIG_ENDIAN = 1'b0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic        wr,
   input  logic [1:0]  size,
   input  logic        sign_ext,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [31:0] rdata,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   lsu_state_e  state_q, state_d;
   logic        wr_q, wr_d;
   logic [1:0]  size_q, size_d;
   logic        sext_q, sext_d;
   logic [1:0]  off_q, off_d;
   logic [31:0] wdata_q, wdata_d;
   logic        done_d, err_d, mem_we_d;
   logic [31:0] rdata_d, mem_addr_d, mem_wdata_d;

   logic        misalign;
   logic        out_of_range;
   logic        req_err;
   logic [1:0]  off_aligned;
   logic [31:0] load_data;
   logic [31:0] store_word;

   alinhador_bytes #(
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_alinhador (
      .size       (size_q),
      .offset     (off_q),
      .sign_ext   (sext_q),
      .rword      (mem_rdata),
      .wdata      (wdata_q),
      .load_data  (load_data),
      .store_word (store_word)
   );

   // Request classification, evaluated on the live request inputs.
   always_comb begin
`ifdef LSU_ALIGN_CHECK_EN
      misalign    = ((size == SZ_HALF) && addr[0]) || ((size == SZ_WORD) && (addr[1:0] != 2'b00));
      off_aligned = addr[1:0];
`else
      misalign = 1'b0;
      if (size == SZ_HALF)      off_aligned = {addr[1], 1'b0};
      else if (size == SZ_WORD) off_aligned = 2'b00;
      else                      off_aligned = addr[1:0];
`endif
      out_of_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
      req_err      = (size == 2'b11) || misalign || out_of_range;
   end

   always_comb begin
      state_d     = state_q;
      wr_d        = wr_q;
      size_d      = size_q;
      sext_d      = sext_q;
      off_d       = off_q;
      wdata_d     = wdata_q;
      done_d      = 1'b0;
      err_d       = 1'b0;
      rdata_d     = rdata;
      mem_we_d    = mem_we;
      mem_addr_d  = mem_addr;
      mem_wdata_d = mem_wdata;

      unique case (state_q)
         IDLE: begin
            if (req) begin
               wr_d       = wr;
               size_d     = size;
               sext_d     = sign_ext;
               off_d      = off_aligned;
               wdata_d    = wdata;
               mem_addr_d = {2'b00, addr[31:2]};
               if (req_err) begin
                  state_d = FIN;
               end else if (!wr || (size != SZ_WORD)) begin
                  // Loads and sub-word stores both need the current word first.
                  state_d = RD;
               end else begin
                  state_d     = WR;
                  mem_we_d    = 1'b1;
                  mem_wdata_d = wdata;
               end
            end
         end
         RD: begin
            if (!wr_q) begin
               rdata_d = load_data;
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               mem_wdata_d = store_word;
               mem_we_d    = 1'b1;
               state_d     = WR;
            end
         end
         WR: begin
            mem_we_d = 1'b0;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         FIN: begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         wr_q      <= 1'b0;
         size_q    <= SZ_BYTE;
         sext_q    <= 1'b0;
         off_q     <= 2'b00;
         wdata_q   <= 32'h0;
         done      <= 1'b0;
         err       <= 1'b0;
         rdata     <= 32'h0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
      end else begin
         state_q   <= state_d;
         wr_q      <= wr_d;
         size_q    <= size_d;
         sext_q    <= sext_d;
         off_q     <= off_d;
         wdata_q   <= wdata_d;
         done      <= done_d;
         err       <= err_d;
         rdata     <= rdata_d;
         mem_we    <= mem_we_d;
         mem_addr  <= mem_addr_d;
         mem_wdata <= mem_wdata_d;
      end
   end

   assign busy = (state_q != IDLE);

endmodule
